module_divisor_secuencial: RTL and testbench

MODULE_DIVISOR_SECUENCIAL -- requirements
Module: module_divisor_secuencial

---
 rtl/divisor_pkg.sv | 15 +
 rtl/module_cambia_datos.sv | 23 ++
 rtl/module_divisor_secuencial.sv | 129 ++++++++++++
 tb/tb_module_divisor_secuencial.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider.
package divisor_pkg;

   // Default operand width and the matching step-index width.
   localparam int N_DEFAULT = 4;
   localparam int IDX_W     = $clog2(N_DEFAULT);

   // Controller states: waiting, iterating quotient bits, presenting result.
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } estado_t;

endpackage

// File: rtl/module_cambia_datos.sv
// Bring-down step of restoring division: shift the partial remainder left
// by one and insert the next dividend bit (MSB first) into its LSB.
module module_cambia_datos
   import divisor_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N:0]    r_in,
   input  logic [N-1:0]  a,
   input  logic [IW-1:0] indice,
   output logic [N:0]    r_out
);

   logic [IW-1:0] pos;

   // Select dividend bit A[N-1-indice] and append it to the shifted remainder.
   always_comb begin
      pos   = IW'(N - 1) - indice;
      r_out = (r_in << 1) | {{N{1'b0}}, a[pos]};
   end

endmodule

// File: rtl/module_divisor_secuencial.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB
// first. Division by zero short-circuits to an all-ones quotient with the
// dividend returned as remainder and div_cero raised.
module module_divisor_secuencial
   import divisor_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividendo,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] cociente,
   output logic [N-1:0] residuo,
   output logic         busy,
   output logic         done,
   output logic         div_cero
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   estado_t       estado;
   estado_t       estado_sig;

   // Operands captured at acceptance so later input changes are harmless.
   logic [N-1:0]  a_reg;
   logic [N-1:0]  b_reg;

   // Working registers: (N+1)-bit partial remainder, quotient, step index.
   logic [N:0]    r_reg;
   logic [N-1:0]  q_reg;
   logic [IW-1:0] idx;

   // Set once all N steps are done; the following CALC cycle hands off to FIN.
   logic          pasos_listos;

   logic [N:0]    r_sh;
   logic [N:0]    r_cmp;
   logic [N:0]    r_next;
   logic [N-1:0]  q_next;
   logic [IW-1:0] pos;
   logic          resta_ok;
   logic          ultimo;

   module_cambia_datos #(
      .N  (N),
      .IW (IW)
   ) u_cambia_datos (
      .r_in   (r_reg),
      .a      (a_reg),
      .indice (idx),
      .r_out  (r_sh)
   );

   // Trial subtraction at N+1 bits; restore (keep r_sh) when it would go negative.
   always_comb begin
      r_cmp     = {1'b0, b_reg};
      resta_ok  = (r_sh >= r_cmp);
      r_next    = resta_ok ? (r_sh - r_cmp) : r_sh;
      pos       = IW'(N - 1) - idx;
      q_next    = q_reg;
      q_next[pos] = resta_ok;
      ultimo    = (idx == IW'(N - 1));
   end

   // Next-state logic for the three-state controller.
   always_comb begin
      estado_sig = estado;
      case (estado)
         IDLE:    if (start) estado_sig = (divisor == '0) ? FIN : CALC;
         CALC:    if (pasos_listos) estado_sig = FIN;
         FIN:     estado_sig = IDLE;
         default: estado_sig = IDLE;
      endcase
   end

   // State, datapath and result registers; results only change on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado       <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         r_reg        <= '0;
         q_reg        <= '0;
         idx          <= '0;
         pasos_listos <= 1'b0;
         cociente     <= '0;
         residuo      <= '0;
         div_cero     <= 1'b0;
      end else begin
         estado <= estado_sig;
         case (estado)
            IDLE: begin
               if (start) begin
                  a_reg        <= dividendo;
                  b_reg        <= divisor;
                  r_reg        <= '0;
                  q_reg        <= '0;
                  idx          <= '0;
                  pasos_listos <= 1'b0;
                  div_cero     <= (divisor == '0);
                  if (divisor == '0) begin
                     cociente <= '1;
                     residuo  <= dividendo;
                  end
               end
            end
            CALC: begin
               if (!pasos_listos) begin
                  r_reg <= r_next;
                  q_reg <= q_next;
                  idx   <= idx + 1'b1;
                  if (ultimo) begin
                     pasos_listos <= 1'b1;
                     cociente     <= q_next;
                     residuo      <= r_next[N-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (estado == CALC);
   assign done = (estado == FIN);

endmodule

// File: tb/tb_module_divisor_secuencial.sv
// Self-checking bench for module_divisor_secuencial: a cycle-level behavioural
// model built from the timing rules (accept edge, result edge, done edge)
// and the / and % operators, compared against the DUT on every cycle.
module tb_module_divisor_secuencial;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] dividendo;
   logic [3:0] divisor;
   logic [3:0] cociente;
   logic [3:0] residuo;
   logic       busy;
   logic       done;
   logic       div_cero;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;
   int dut_done_cnt   = 0;
   int model_done_cnt = 0;

   // Model state
   int         age = -1;
   int         pa, pb, res_at, done_at;
   logic [3:0] m_q = '0;
   logic [3:0] m_r = '0;
   logic       m_dz = 1'b0;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;

   module_divisor_secuencial #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividendo (dividendo),
      .divisor   (divisor),
      .cociente  (cociente),
      .residuo   (residuo),
      .busy      (busy),
      .done      (done),
      .div_cero  (div_cero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: age counts edges since the accepting edge.
   always @(posedge clk) begin
      if (rst) begin
         age = -1; m_q = '0; m_r = '0; m_dz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end else begin
         if (age >= 0) age++;
         else if (start) begin
            pa = int'(dividendo);
            pb = int'(divisor);
            age = 0;
            m_dz = (pb == 0);
            res_at  = (pb == 0) ? 0 : N;
            done_at = (pb == 0) ? 0 : N + 1;
         end
         if (age >= 0) begin
            if (age == res_at) begin
               if (pb == 0) begin m_q = 4'hF; m_r = 4'(pa); end
               else begin m_q = 4'(pa / pb); m_r = 4'(pa % pb); end
            end
            m_busy = (pb != 0) && (age <= N);
            m_done = (age == done_at);
            if (m_done) model_done_cnt++;
            if (age == done_at + 1) age = -1;
         end else begin
            m_busy = 1'b0;
            m_done = 1'b0;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", int'(busy), int'(m_busy));
         chk("done", int'(done), int'(m_done));
         chk("div_cero", int'(div_cero), int'(m_dz));
         chk("cociente", int'(cociente), int'(m_q));
         chk("residuo", int'(residuo), int'(m_r));
         if (done) dut_done_cnt++;
      end
   end

   task automatic wait_done(output bit ok);
      int cnt = 0;
      while (!done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      ok = done;
      if (!ok) chk("timeout_done", 0, 1);
   endtask

   task automatic run_div(input logic [3:0] a, input logic [3:0] b, input bit noisy);
      int cnt = 0;
      start = 1'b1; dividendo = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      dividendo = 4'($urandom);
      divisor   = 4'($urandom);
      while (!done && cnt < 20) begin
         if (noisy) begin
            start     = 1'($urandom);
            dividendo = 4'($urandom);
            divisor   = 4'($urandom);
         end
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      if (!done) chk("timeout_run", 0, 1);
      else begin
         chk("run_q", int'(cociente), (b == 0) ? 15 : int'(a) / int'(b));
         chk("run_r", int'(residuo), (b == 0) ? int'(a) : int'(a) % int'(b));
         chk("run_dz", int'(div_cero), (b == 0) ? 1 : 0);
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int dones, cnt, c1, c2;
      rst = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_q", int'(cociente), 0);
      chk("rst_r", int'(residuo), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_dz", int'(div_cero), 0);
      rst = 1'b0;
      @(negedge clk);

      // 13/4 with explicit timing, first start after reset.
      start = 1'b1; dividendo = 4'd13; divisor = 4'd4;
      @(negedge clk);
      start = 1'b0; dividendo = 4'd0; divisor = 4'd0;
      chk("13_4_busy_k", int'(busy), 1);
      repeat (4) @(negedge clk);
      chk("13_4_q", int'(cociente), 3);
      chk("13_4_r", int'(residuo), 1);
      chk("13_4_busy_k4", int'(busy), 1);
      chk("13_4_done_k4", int'(done), 0);
      chk("model_13_4_q", int'(m_q), 3);
      chk("model_13_4_r", int'(m_r), 1);
      @(negedge clk);
      chk("13_4_done", int'(done), 1);
      chk("13_4_busy_k5", int'(busy), 0);
      chk("13_4_dz", int'(div_cero), 0);
      @(negedge clk);
      chk("13_4_done_off", int'(done), 0);

      run_div(4'd15, 4'd1, 1'b0);
      run_div(4'd3,  4'd7, 1'b0);
      run_div(4'd0,  4'd5, 1'b0);

      // 9/0: result one cycle after acceptance, never busy.
      start = 1'b1; dividendo = 4'd9; divisor = 4'd0;
      @(negedge clk);
      start = 1'b0;
      chk("9_0_q", int'(cociente), 15);
      chk("9_0_r", int'(residuo), 9);
      chk("9_0_dz", int'(div_cero), 1);
      chk("9_0_done", int'(done), 1);
      chk("9_0_busy", int'(busy), 0);
      chk("model_9_0_q", int'(m_q), 15);
      @(negedge clk);
      chk("9_0_done_off", int'(done), 0);
      chk("9_0_dz_hold", int'(div_cero), 1);
      @(negedge clk);

      // 12/5 with a 1/1 start pulse during CALC.
      start = 1'b1; dividendo = 4'd12; divisor = 4'd5;
      @(negedge clk);
      start = 1'b1; dividendo = 4'd1; divisor = 4'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(ok);
      chk("12_5_q", int'(cociente), 2);
      chk("12_5_r", int'(residuo), 2);
      repeat (3) begin
         @(negedge clk);
         chk("12_5_no_restart", int'(busy), 0);
      end

      // 14/3 aborted by reset at step 2, then rerun.
      start = 1'b1; dividendo = 4'd14; divisor = 4'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_q", int'(cociente), 0);
      chk("abort_r", int'(residuo), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_dz", int'(div_cero), 0);
      rst = 1'b0;
      @(negedge clk);
      run_div(4'd14, 4'd3, 1'b0);
      chk("14_3_q", int'(cociente), 4);
      chk("14_3_r", int'(residuo), 2);

      // start held high: back-to-back divisions 7 cycles apart.
      start = 1'b1; dividendo = 4'd6; divisor = 4'd2;
      dones = 0; cnt = 0; c1 = 0; c2 = 0;
      while (dones < 2 && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (done) begin
            dones++;
            if (dones == 1) c1 = cnt; else c2 = cnt;
         end
      end
      start = 1'b0;
      chk("held_dones", dones, 2);
      chk("held_gap", c2 - c1, 7);
      chk("held_q", int'(cociente), 3);
      @(negedge clk);

      // Exhaustive operand sweep.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_div(4'(a), 4'(b), 1'b0);

      // Randomized operands with random start noise during the operation.
      for (int i = 0; i < 40; i++)
         run_div(4'($urandom), 4'($urandom), 1'b1);

      @(negedge clk);
      chk("done_count", dut_done_cnt, model_done_cnt);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
